// File: rtl/param_line_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : param_line_buffer_if
//  Description : Bundle of the write/read/status signals of param_line_buffer.
//                The master modport is the pixel source / window consumer;
//                the slave modport is the line buffer itself.
//                  i_clr         synchronous clear of pointers/count/overflow
//                  i_data        incoming pixel
//                  i_data_valid  write strobe for i_data
//                  i_rd_data     consume request (advance window)
//                  o_data        KERNEL_W-pixel window, MSB slice = oldest tap
//                  o_win_valid   o_data holds a complete window
//                  o_eol         current window is the last of the row
//                  o_full        buffer holds LINE_W pixels
//                  o_count       pixels stored and not yet consumed
//                  o_overflow    sticky: write attempted while full
//  Revision    : 1.0 - initial release
// ============================================================================
interface param_line_buffer_if #(
    parameter int DATA_W   = 8,
    parameter int LINE_W   = 512,
    parameter int KERNEL_W = 3
);
    localparam int CNT_W = $clog2(LINE_W + 1);

    logic                       i_clr;
    logic [DATA_W-1:0]          i_data;
    logic                       i_data_valid;
    logic                       i_rd_data;
    logic [DATA_W*KERNEL_W-1:0] o_data;
    logic                       o_win_valid;
    logic                       o_eol;
    logic                       o_full;
    logic [CNT_W-1:0]           o_count;
    logic                       o_overflow;

    modport master (
        output i_clr, i_data, i_data_valid, i_rd_data,
        input  o_data, o_win_valid, o_eol, o_full, o_count, o_overflow
    );

    modport slave (
        input  i_clr, i_data, i_data_valid, i_rd_data,
        output o_data, o_win_valid, o_eol, o_full, o_count, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/param_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : param_line_buffer
//  Description : Single image-row pixel buffer for KERNEL_W-wide sliding
//                window filters. Presents KERNEL_W horizontally adjacent
//                pixels starting at the read pointer, with occupancy, full,
//                window-valid, end-of-line and sticky overflow status.
//                Optional feature macro: BORDER_REPLICATE_EN
//                  defined   -> one window per column, taps past the last
//                               column replicate the last pixel
//                  undefined -> LINE_W-KERNEL_W+1 windows per row, the
//                               trailing KERNEL_W-1 pixels are skipped at eol
//  Ports       : i_clk    clock (rising edge)
//                i_rst_n  asynchronous active-low reset
//                bus      param_line_buffer_if.slave (data/handshake/status)
//  Revision    : 1.0 - initial release
// ============================================================================
module param_line_buffer #(
    parameter int DATA_W   = 8,
    parameter int LINE_W   = 512,
    parameter int KERNEL_W = 3
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    param_line_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(LINE_W);
    localparam int CNT_W = $clog2(LINE_W + 1);

    localparam logic [PTR_W-1:0] c_PTR_LAST   = PTR_W'(LINE_W - 1);
    localparam logic [CNT_W-1:0] c_LINE_CNT   = CNT_W'(LINE_W);
    localparam logic [CNT_W-1:0] c_KERNEL_CNT = CNT_W'(KERNEL_W);
`ifdef BORDER_REPLICATE_EN
    localparam logic [PTR_W-1:0] c_EOL_PTR    = c_PTR_LAST;
`else
    localparam logic [PTR_W-1:0] c_EOL_PTR    = PTR_W'(LINE_W - KERNEL_W);
`endif

    logic [DATA_W-1:0] r_mem [LINE_W];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;

    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_overflow_nxt;
    logic [CNT_W-1:0]  w_need;
    logic [CNT_W-1:0]  w_consumed;
    logic              w_full;
    logic              w_eol;
    logic              w_win_valid;
    logic              w_wr_en;
    logic              w_rd_en;

    // ------------------------------------------------------------------
    // Status decode (all from current state)
    // ------------------------------------------------------------------
    always_comb begin
        w_full = (r_count == c_LINE_CNT);
        w_eol  = (r_rd_ptr == c_EOL_PTR);
`ifdef BORDER_REPLICATE_EN
        // Near the right edge fewer real pixels are needed for a window.
        w_need = c_LINE_CNT - CNT_W'(r_rd_ptr);
        if (w_need > c_KERNEL_CNT) begin
            w_need = c_KERNEL_CNT;
        end
        w_consumed = CNT_W'(1);
`else
        w_need     = c_KERNEL_CNT;
        // At eol the trailing KERNEL_W-1 pixels of the row are dropped too.
        w_consumed = w_eol ? c_KERNEL_CNT : CNT_W'(1);
`endif
        w_win_valid = (r_count >= w_need);
        w_wr_en     = bus.i_data_valid && !w_full;
        w_rd_en     = bus.i_rd_data && w_win_valid;
    end

    // ------------------------------------------------------------------
    // Next-state logic; clear overrides any write or read
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        if (bus.i_clr) begin
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_wr_en) begin
                w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (bus.i_data_valid && w_full) begin
                w_overflow_nxt = 1'b1;
            end
            // Both modes land on column 0 after eol: default jumps by
            // KERNEL_W from LINE_W-KERNEL_W, border steps by 1 from LINE_W-1.
            if (w_rd_en) begin
                w_rd_ptr_nxt = w_eol ? '0 : r_rd_ptr + PTR_W'(1);
            end
            w_count_nxt = r_count + {{(CNT_W-1){1'b0}}, w_wr_en}
                        - (w_rd_en ? w_consumed : '0);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Pixel storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en && !bus.i_clr) begin
            r_mem[r_wr_ptr] <= bus.i_data;
        end
    end

    // ------------------------------------------------------------------
    // Window taps: zero-latency reads at rd_ptr+k
    // ------------------------------------------------------------------
    for (genvar k = 0; k < KERNEL_W; k++) begin : g_tap
        logic [PTR_W:0]   w_sum;
        logic [PTR_W-1:0] w_idx;
        always_comb begin
            w_sum = {1'b0, r_rd_ptr} + (PTR_W+1)'(k);
`ifdef BORDER_REPLICATE_EN
            w_idx = (w_sum > {1'b0, c_PTR_LAST}) ? c_PTR_LAST : w_sum[PTR_W-1:0];
`else
            w_idx = (w_sum >= (PTR_W+1)'(LINE_W)) ? (w_sum[PTR_W-1:0] - PTR_W'(LINE_W))
                                                  : w_sum[PTR_W-1:0];
`endif
        end
        assign bus.o_data[(KERNEL_W-k)*DATA_W-1 -: DATA_W] = r_mem[w_idx];
    end

    assign bus.o_win_valid = w_win_valid;
    assign bus.o_eol       = w_eol;
    assign bus.o_full      = w_full;
    assign bus.o_count     = r_count;
    assign bus.o_overflow  = r_overflow;

endmodule
`default_nettype wire
